// File: rtl/divsu_iter.sv
// Iterative signed/unsigned divider: one non-restoring step per cycle on operand
// magnitudes, followed by a fix-up cycle for the remainder, the signs and divide-by-zero.
module divsu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_pr;      // signed partial remainder
    logic [WIDTH-1:0] r_quo;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_orig;
    logic             r_neg_q, r_neg_r, r_dz;
    logic [WIDTH-1:0] r_q, r_r;
    logic             r_done, r_div_zero;

    logic             w_sd, w_sv;
    logic [WIDTH-1:0] w_mag_dd, w_mag_dv;
    logic [WIDTH:0]   w_pr_sh, w_pr_nx, w_rem_fix;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem, w_q_fin, w_r_fin;

    // Unsigned negation keeps MIN as 2^(WIDTH-1), so MIN / -1 needs no special case.
    assign w_sd     = is_signed & dividend[WIDTH-1];
    assign w_sv     = is_signed & divisor[WIDTH-1];
    assign w_mag_dd = w_sd ? (~dividend + 1'b1) : dividend;
    assign w_mag_dv = w_sv ? (~divisor + 1'b1) : divisor;

    assign w_pr_sh  = {r_pr[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_pr_nx  = r_pr[WIDTH] ? (w_pr_sh + {1'b0, r_dvs}) : (w_pr_sh - {1'b0, r_dvs});
    assign w_qbit   = ~w_pr_nx[WIDTH];

    assign w_rem_fix = r_pr[WIDTH] ? (r_pr + {1'b0, r_dvs}) : r_pr;
    assign w_rem     = w_rem_fix[WIDTH-1:0];
    assign w_q_fin   = r_dz ? {WIDTH{1'b1}} : (r_neg_q ? (~r_quo + 1'b1) : r_quo);
    assign w_r_fin   = r_dz ? r_orig : (r_neg_r ? (~w_rem + 1'b1) : w_rem);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CALC;
            S_CALC:  if (r_cnt == LAST) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_pr       <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_orig     <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz       <= 1'b0;
            r_q        <= '0;
            r_r        <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_quo      <= w_mag_dd;
                        r_dvs      <= w_mag_dv;
                        r_orig     <= dividend;
                        r_neg_q    <= w_sd ^ w_sv;
                        r_neg_r    <= w_sd;
                        r_dz       <= (divisor == '0);
                        r_pr       <= '0;
                        r_cnt      <= '0;
                        r_div_zero <= 1'b0;
                    end
                end
                S_CALC: begin
                    r_pr  <= w_pr_nx;
                    r_quo <= {r_quo[WIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_q        <= w_q_fin;
                    r_r        <= w_r_fin;
                    r_div_zero <= r_dz;
                    r_done     <= 1'b1;
                    r_cnt      <= '0;
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

    assign q        = r_q;
    assign r        = r_r;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_divsu_iter.sv
// Scoreboard bench for divsu_iter: drivers push expected results, per-instance
// monitors pop and compare on every done pulse, also checking busy length.
module tb_divsu_iter;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst32, rst8;
    logic [31:0] dd32, dv32;
    logic        sg32, st32;
    logic [31:0] q32, r32;
    logic        busy32, done32, dz32;
    logic [7:0]  dd8, dv8;
    logic        sg8, st8;
    logic [7:0]  q8, r8;
    logic        busy8, done8, dz8;

    exp_t exp32_q[$];
    exp_t exp8_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    divsu_iter #(.WIDTH(32)) u_d32 (
        .clock(clk), .reset(rst32), .dividend(dd32), .divisor(dv32),
        .is_signed(sg32), .start(st32), .q(q32), .r(r32),
        .busy(busy32), .done(done32), .div_zero(dz32)
    );

    divsu_iter #(.WIDTH(8)) u_d8 (
        .clock(clk), .reset(rst8), .dividend(dd8), .divisor(dv8),
        .is_signed(sg8), .start(st8), .q(q8), .r(r8),
        .busy(busy8), .done(done8), .div_zero(dz8)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endfunction

    // Monitor for the 32-bit instance
    int  bcnt32 = 0;
    logic pdone32 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst32) begin
            bcnt32 = 0;
        end else begin
            if (busy32) bcnt32++;
            if (done32) begin
                check("d32_done_one_cycle", {31'b0, pdone32}, 32'd0);
                check("d32_done_not_busy", {31'b0, busy32}, 32'd0);
                check("d32_busy_cycles", bcnt32, 32'd33);
                if (exp32_q.size() == 0) begin
                    check("d32_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp32_q.pop_front();
                    check("d32_q", q32, e.q);
                    check("d32_r", r32, e.r);
                    check("d32_div_zero", {31'b0, dz32}, {31'b0, e.dz});
                end
                bcnt32 = 0;
            end
        end
        pdone32 = done32;
    end

    // Monitor for the 8-bit instance
    int  bcnt8 = 0;
    logic pdone8 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst8) begin
            bcnt8 = 0;
        end else begin
            if (busy8) bcnt8++;
            if (done8) begin
                check("d8_done_one_cycle", {31'b0, pdone8}, 32'd0);
                check("d8_busy_cycles", bcnt8, 32'd9);
                if (exp8_q.size() == 0) begin
                    check("d8_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp8_q.pop_front();
                    check("d8_q", {24'b0, q8}, e.q);
                    check("d8_r", {24'b0, r8}, e.r);
                    check("d8_div_zero", {31'b0, dz8}, {31'b0, e.dz});
                end
                bcnt8 = 0;
            end
        end
        pdone8 = done8;
    end

    task automatic wait_done32();
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (done32) seen = 1;
        end
        if (!seen) check("d32_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_done8();
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (done8) seen = 1;
        end
        if (!seen) check("d8_timeout", 32'd1, 32'd0);
    endtask

    // Issue at a negedge; after the accept edge check busy/div_zero, scramble operands.
    task automatic accept32(input logic [31:0] a, input logic [31:0] b, input logic s);
        dd32 = a; dv32 = b; sg32 = s; st32 = 1'b1;
        @(posedge clk); #1;
        st32 = 1'b0;
        check("d32_busy_after_accept", {31'b0, busy32}, 32'd1);
        check("d32_dz_clear_on_accept", {31'b0, dz32}, 32'd0);
        dd32 = $urandom; dv32 = $urandom; sg32 = ~s;
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz);
        exp32_q.push_back('{q: eq, r: er, dz: edz});
        accept32(a, b, s);
        wait_done32();
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz);
        exp8_q.push_back('{q: {24'b0, eq}, r: {24'b0, er}, dz: edz});
        dd8 = a; dv8 = b; sg8 = s; st8 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0;
        dd8 = 8'hA5; dv8 = 8'h00;
        wait_done8();
    endtask

    initial begin
        rst32 = 1'b0; rst8 = 1'b0;
        st32 = 1'b0; st8 = 1'b0;
        dd32 = '0; dv32 = '0; sg32 = 1'b0;
        dd8 = '0; dv8 = '0; sg8 = 1'b0;
        #1;
        check("rst_q32", q32, 32'd0);
        check("rst_r32", r32, 32'd0);
        check("rst_ctl32", {29'b0, busy32, done32, dz32}, 32'd0);
        check("rst_ctl8", {q8, r8, 13'b0, busy8, done8, dz8}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst32 = 1'b1; rst8 = 1'b1;
        @(negedge clk);

        // Back-to-back: each call issues at the negedge where the previous done was seen
        run32(32'd100,       32'd7,       1'b0, 32'd14,        32'd2,        1'b0);
        run32(32'hFFFFFFF9,  32'd2,       1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF, 1'b0);
        run32(32'd7,         32'hFFFFFFFE,1'b1, 32'hFFFFFFFD,  32'd1,        1'b0);
        run32(32'hFFFFFFF9,  32'hFFFFFFFE,1'b1, 32'd3,         32'hFFFFFFFF, 1'b0);
        run32(32'h80000000,  32'hFFFFFFFF,1'b1, 32'h80000000,  32'd0,        1'b0);
        run32(32'h80000000,  32'hFFFFFFFF,1'b0, 32'd0,         32'h80000000, 1'b0);
        run32(32'hFFFFFFFF,  32'd10,      1'b0, 32'h19999999,  32'd5,        1'b0);
        run32(32'd5,         32'd0,       1'b0, 32'hFFFFFFFF,  32'd5,        1'b1);
        run32(32'd5,         32'd0,       1'b1, 32'hFFFFFFFF,  32'd5,        1'b1);
        run32(32'hFFFFFFFB,  32'd0,       1'b1, 32'hFFFFFFFF,  32'hFFFFFFFB, 1'b1);
        run32(32'd100,       32'd7,       1'b0, 32'd14,        32'd2,        1'b0);

        // start pulsed mid-division must be ignored
        exp32_q.push_back('{q: 32'd142, r: 32'd6, dz: 1'b0});
        accept32(32'd1000, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        dd32 = 32'd1; dv32 = 32'd1; sg32 = 1'b0; st32 = 1'b1;
        @(negedge clk);
        st32 = 1'b0;
        wait_done32();
        repeat (3) @(negedge clk);

        // reset mid-division: abandoned, no done
        accept32(32'd12345, 32'd11, 1'b0);
        repeat (19) @(negedge clk);
        rst32 = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy32}, 32'd0);
        check("abort_q", q32, 32'd0);
        check("abort_r", r32, 32'd0);
        check("abort_done", {31'b0, done32}, 32'd0);
        repeat (2) @(negedge clk);
        rst32 = 1'b1;
        repeat (40) @(negedge clk);
        run32(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

        run8(8'd200, 8'd3,   1'b0, 8'd66,  8'd2,  1'b0);
        run8(8'h80,  8'd3,   1'b1, 8'hD6,  8'hFE, 1'b0);
        run8(8'h80,  8'hFF,  1'b1, 8'h80,  8'h00, 1'b0);
        run8(8'd7,   8'd0,   1'b0, 8'hFF,  8'd7,  1'b1);
        run8(8'd25,  8'hFB,  1'b1, 8'hFB,  8'd0,  1'b0);

        repeat (3) @(negedge clk);
        check("d32_queue_empty", exp32_q.size(), 32'd0);
        check("d8_queue_empty", exp8_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
